regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (wa/we/wd) between two writeback sources: execute stage (EX) and the cache/memory load-return path (MEM).
- Fixed priority to MEM, with an anti-starvation counter that guarantees EX progress.
- Registered outputs drive the register file directly. Writes to x0 are consumed and never issued.

---
 rtl/regfile_wb_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter sharing the single register-file write port between the
// execute stage (EX) and the memory load-return path (MEM). MEM normally has
// priority. A starvation counter eventually hands priority to EX. Writes to x0
// complete their handshake but never reach the register file.
module regfile_wb_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [4:0]       ex_wa,
    input  logic [WIDTH-1:0] ex_wd,
    output logic             ex_ready,
    input  logic             mem_valid,
    input  logic [4:0]       mem_wa,
    input  logic [WIDTH-1:0] mem_wd,
    output logic             mem_ready,
    output logic             rf_we,
    output logic [4:0]       rf_wa,
    output logic [WIDTH-1:0] rf_wd,
    output logic [3:0]       starve_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {
        PRIO_MEM,
        PRIO_EX
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       starveCnt_q, starveCnt_d;
    logic             rfWe_q, rfWe_d;
    logic [4:0]       rfWa_q, rfWa_d;
    logic [WIDTH-1:0] rfWd_q, rfWd_d;

    logic sameDest;
    logic exXfer;
    logic memXfer;

    assign sameDest = ex_valid && mem_valid && (ex_wa == mem_wa) && (ex_wa != 5'd0);
    assign exXfer   = ex_valid && ex_ready;
    assign memXfer  = mem_valid && mem_ready;

    // Grant selection: an older MEM write to the same register always goes first,
    // otherwise the current priority state decides who is accepted.
    always_comb begin
        ex_ready  = 1'b0;
        mem_ready = 1'b0;
        if (!rst_n) begin
            ex_ready  = 1'b0;
            mem_ready = 1'b0;
        end else if (sameDest) begin
            mem_ready = 1'b1;
        end else if (state_q == PRIO_EX) begin
            ex_ready  = ex_valid;
            mem_ready = ~ex_valid;
        end else begin
            mem_ready = mem_valid;
            ex_ready  = ex_valid && !mem_valid;
        end
    end

    // Starvation count and priority-state transitions for the next cycle.
    always_comb begin
        starveCnt_d = 4'd0;
        state_d     = state_q;
        if (ex_valid && !ex_ready) begin
            starveCnt_d = (starveCnt_q == 4'd15) ? 4'd15 : starveCnt_q + 4'd1;
        end
        case (state_q)
            PRIO_MEM: begin
                if (starveCnt_d >= LIMIT) begin
                    state_d = PRIO_EX;
                end
            end
            PRIO_EX: begin
                if (exXfer || !ex_valid) begin
                    state_d = PRIO_MEM;
                end
            end
            default: state_d = PRIO_MEM;
        endcase
    end

    // Output register contents: the accepted write, suppressed when it targets x0.
    always_comb begin
        rfWe_d = 1'b0;
        rfWa_d = rfWa_q;
        rfWd_d = rfWd_q;
        if (memXfer) begin
            if (mem_wa != 5'd0) begin
                rfWe_d = 1'b1;
                rfWa_d = mem_wa;
                rfWd_d = mem_wd;
            end
        end else if (exXfer) begin
            if (ex_wa != 5'd0) begin
                rfWe_d = 1'b1;
                rfWa_d = ex_wa;
                rfWd_d = ex_wd;
            end
        end
    end

    // State and output registers; reset drops any in-flight write immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PRIO_MEM;
            starveCnt_q <= 4'd0;
            rfWe_q      <= 1'b0;
            rfWa_q      <= 5'd0;
            rfWd_q      <= '0;
        end else begin
            state_q     <= state_d;
            starveCnt_q <= starveCnt_d;
            rfWe_q      <= rfWe_d;
            rfWa_q      <= rfWa_d;
            rfWd_q      <= rfWd_d;
        end
    end

    assign rf_we      = rfWe_q;
    assign rf_wa      = rfWa_q;
    assign rf_wd      = rfWd_q;
    assign starve_cnt = starveCnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: requesters hold requests until accepted,
// a reference model predicts each cycle's winner and pushes expected writes,
// and a monitor pops them whenever the arbiter issues a register-file write.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [4:0]  ex_wa;
    logic [31:0] ex_wd;
    logic        ex_ready;
    logic        mem_valid;
    logic [4:0]  mem_wa;
    logic [31:0] mem_wd;
    logic        mem_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [3:0]  starve_cnt;

    regfile_wb_arbiter #(.WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_wa      (ex_wa),
        .ex_wd      (ex_wd),
        .ex_ready   (ex_ready),
        .mem_valid  (mem_valid),
        .mem_wa     (mem_wa),
        .mem_wd     (mem_wd),
        .mem_ready  (mem_ready),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .starve_cnt (starve_cnt)
    );

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    int          checkCount = 0;
    int          passCount  = 0;
    wr_t         expQ[$];
    wr_t         seen;
    logic [31:0] benchRf [32];
    logic [31:0] modelRf [32];

    logic        memV = 1'b0;
    logic [4:0]  memWaR = 5'd0;
    logic [31:0] memWdR = 32'd0;
    logic        exV = 1'b0;
    logic [4:0]  exWaR = 5'd0;
    logic [31:0] exWdR = 32'd0;
    logic        dutMemAcc = 1'b0;
    logic        dutExAcc = 1'b0;
    int          waited = 0;
    logic        boost = 1'b0;
    int          exIdx;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // One arbitration cycle: drive requests, predict the winner from the
    // priority rules, compare accepts, queue the expected write, retire winners.
    task automatic applyStimulus();
        logic gMem;
        logic gEx;
        wr_t  w;
        mem_valid = memV;
        mem_wa    = memWaR;
        mem_wd    = memWdR;
        ex_valid  = exV;
        ex_wa     = exWaR;
        ex_wd     = exWdR;
        #3;
        gMem = 1'b0;
        gEx  = 1'b0;
        if (memV && exV && memWaR == exWaR && exWaR != 5'd0) begin
            gMem = 1'b1;
        end else if (boost) begin
            if (exV) gEx = 1'b1;
            else if (memV) gMem = 1'b1;
        end else begin
            if (memV) gMem = 1'b1;
            else if (exV) gEx = 1'b1;
        end
        dutMemAcc = mem_valid & mem_ready;
        dutExAcc  = ex_valid & ex_ready;
        checkOutput("mem_accept", 32'(dutMemAcc), 32'(gMem));
        checkOutput("ex_accept", 32'(dutExAcc), 32'(gEx));
        checkOutput("starve_cnt", 32'(starve_cnt), waited);
        if (gMem && memWaR != 5'd0) begin
            w.wa = memWaR;
            w.wd = memWdR;
            expQ.push_back(w);
            modelRf[memWaR] = memWdR;
        end
        if (gEx && exWaR != 5'd0) begin
            w.wa = exWaR;
            w.wd = exWdR;
            expQ.push_back(w);
            modelRf[exWaR] = exWdR;
        end
        if (exV && !gEx) begin
            waited = (waited < 15) ? waited + 1 : 15;
            if (waited >= LIMIT) boost = 1'b1;
        end else begin
            waited = 0;
            boost  = 1'b0;
        end
        @(posedge clk);
        #1;
        if (dutMemAcc) memV = 1'b0;
        if (dutExAcc) exV = 1'b0;
    endtask

    // Shadow register file built only from what the arbiter actually issues.
    always @(posedge clk) begin
        if (rf_we) benchRf[rf_wa] <= rf_wd;
    end

    // Monitor: every issued write must match the oldest predicted write.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write_wa", 32'(rf_wa), 32'hFFFF_FFFF);
            end else begin
                seen = expQ.pop_front();
                checkOutput("write_wa", 32'(rf_wa), 32'(seen.wa));
                checkOutput("write_wd", rf_wd, seen.wd);
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        rst_n     = 1'b0;
        memV = 1'b1; memWaR = 5'd4; memWdR = 32'hA5A5_0004;
        exV  = 1'b1; exWaR  = 5'd5; exWdR  = 32'h5A5A_0005;
        mem_valid = 1'b1; mem_wa = memWaR; mem_wd = memWdR;
        ex_valid  = 1'b1; ex_wa  = exWaR;  ex_wd  = exWdR;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rf_we", 32'(rf_we), 32'd0);
        checkOutput("reset_rf_wa", 32'(rf_wa), 32'd0);
        checkOutput("reset_rf_wd", rf_wd, 32'd0);
        checkOutput("reset_mem_ready", 32'(mem_ready), 32'd0);
        checkOutput("reset_ex_ready", 32'(ex_ready), 32'd0);
        checkOutput("reset_starve_cnt", 32'(starve_cnt), 32'd0);
        rst_n = 1'b1;

        applyStimulus();
        checkOutput("first_after_reset_mem", 32'(dutMemAcc), 32'd1);
        applyStimulus();

        $display("[TB] single EX write");
        exV = 1'b1; exWaR = 5'd5; exWdR = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("single_ex_we", 32'(rf_we), 32'd1);
        checkOutput("single_ex_wa", 32'(rf_wa), 32'd5);
        checkOutput("single_ex_wd", rf_wd, 32'hDEADBEEF);

        $display("[TB] starvation");
        exV = 1'b1; exWaR = 5'd3; exWdR = $urandom;
        exIdx = -1;
        for (int i = 0; i < 10; i++) begin
            if (!memV) begin memV = 1'b1; memWaR = 5'(10 + i); memWdR = $urandom; end
            applyStimulus();
            if (dutExAcc) begin exIdx = i; break; end
        end
        checkOutput("starve_ex_cycle", 32'(exIdx), 32'd4);
        if (!memV) begin memV = 1'b1; memWaR = 5'd30; memWdR = $urandom; end
        applyStimulus();
        checkOutput("starve_mem_resume", 32'(dutMemAcc), 32'd1);

        $display("[TB] same destination under EX priority");
        exV = 1'b1; exWaR = 5'd7; exWdR = 32'd2;
        exIdx = -1;
        for (int i = 0; i < 10; i++) begin
            if (!memV && i <= 4) begin
                memV   = 1'b1;
                memWaR = (i == 4) ? 5'd7 : 5'(20 + i);
                memWdR = (i == 4) ? 32'd1 : $urandom;
            end
            applyStimulus();
            if (dutExAcc) begin exIdx = i; break; end
        end
        checkOutput("samedest_ex_cycle", 32'(exIdx), 32'd5);
        applyStimulus();
        applyStimulus();
        checkOutput("samedest_reg7", benchRf[7], modelRf[7]);

        $display("[TB] x0 write");
        memV = 1'b1; memWaR = 5'd0; memWdR = 32'hFFFFFFFF;
        applyStimulus();
        checkOutput("x0_accept", 32'(dutMemAcc), 32'd1);
        checkOutput("x0_no_write", 32'(rf_we), 32'd0);

        $display("[TB] async reset during write");
        memV = 1'b1; memWaR = 5'd9; memWdR = 32'h1234_5678;
        applyStimulus();
        checkOutput("prereset_we", 32'(rf_we), 32'd1);
        #1;
        rst_n     = 1'b0;
        mem_valid = 1'b1;
        ex_valid  = 1'b1;
        #1;
        checkOutput("async_reset_we", 32'(rf_we), 32'd0);
        checkOutput("async_reset_mem_ready", 32'(mem_ready), 32'd0);
        checkOutput("async_reset_ex_ready", 32'(ex_ready), 32'd0);
        expQ.delete();
        memV = 1'b0; exV = 1'b0; waited = 0; boost = 1'b0;
        #1;
        rst_n = 1'b1;

        $display("[TB] random traffic");
        for (int n = 0; n < 300; n++) begin
            if (!memV && $urandom_range(0, 2) != 0) begin
                memV = 1'b1; memWaR = 5'($urandom_range(0, 7)); memWdR = $urandom;
            end
            if (!exV && $urandom_range(0, 2) != 0) begin
                exV = 1'b1; exWaR = 5'($urandom_range(0, 7)); exWdR = $urandom;
            end
            applyStimulus();
        end
        for (int n = 0; n < 40 && (memV || exV); n++) begin
            applyStimulus();
        end
        applyStimulus();
        applyStimulus();
        checkOutput("drain_empty", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
